scan_chain_ctrl: RTL and testbench



---
 rtl/scan_chain_ctrl_pkg.sv | 14 +
 rtl/scan_chain_ctrl_if.sv | 26 ++
 rtl/scan_chain_ctrl_shreg.sv | 21 ++
 rtl/scan_chain_ctrl.sv | 105 ++++++++++
 tb/tb_scan_chain_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/scan_chain_ctrl_pkg.sv
// Shared constants for the scan chain controller: default sizes and FSM encodings.
// Build option: SCAN_CAPTURE_EN adds the CAPT/UNLOAD states.
package scan_chain_ctrl_pkg;
    localparam int DEF_N  = 8;
    localparam int DEF_CW = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SHIFT  = 3'd1;
    localparam logic [2:0] ST_FIN    = 3'd2;
`ifdef SCAN_CAPTURE_EN
    localparam logic [2:0] ST_CAPT   = 3'd3;
    localparam logic [2:0] ST_UNLOAD = 3'd4;
`endif
endpackage

// File: rtl/scan_chain_ctrl_if.sv
// Host handshake plus scan-chain pins of the scan chain controller.
interface scan_chain_ctrl_if
    import scan_chain_ctrl_pkg::*;
#(
    parameter int N = DEF_N
);
    logic         START;
    logic [N-1:0] LOAD_DATA;
    logic         FUNC_EN;
    logic         SCANOUT;
    logic         TEST;
    logic         SCANIN;
    logic         HOLD;
    logic         BUSY;
    logic         DONE;
    logic [N-1:0] CAPT_DATA;

    modport slave (
        input  START, LOAD_DATA, FUNC_EN, SCANOUT,
        output TEST, SCANIN, HOLD, BUSY, DONE, CAPT_DATA
    );
    modport master (
        output START, LOAD_DATA, FUNC_EN, SCANOUT,
        input  TEST, SCANIN, HOLD, BUSY, DONE, CAPT_DATA
    );
endinterface

// File: rtl/scan_chain_ctrl_shreg.sv
// N-bit left-shift register: parallel load, synchronous clear, serial-in at bit 0.
module scan_shreg #(
    parameter int N = 8
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic         clr,
    input  logic         load,
    input  logic         shift,
    input  logic         sin,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)    q <= '0;
        else if (clr)   q <= '0;
        else if (load)  q <= d;
        // truncating cast keeps this legal for N=1
        else if (shift) q <= N'({q, sin});
    end
endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: shifts a pattern into the chain MSB-first while unloading
// the old contents into CAPT_DATA. Build option: SCAN_CAPTURE_EN (capture + unload pass).
module scan_chain_ctrl
    import scan_chain_ctrl_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int CW = DEF_CW
) (
    input logic             CLK,
    input logic             CLR,
    scan_chain_ctrl_if.slave bus
);
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  pat_q;
    logic          accept, last, pat_shift, capt_shift, capt_clr;

    assign accept    = (state == ST_IDLE) && bus.START;
    assign last      = (cnt == CW'(N - 1));
    assign pat_shift = (state == ST_SHIFT);
`ifdef SCAN_CAPTURE_EN
    assign capt_shift = (state == ST_SHIFT) || (state == ST_UNLOAD);
    assign capt_clr   = (state == ST_CAPT);
`else
    assign capt_shift = pat_shift;
    assign capt_clr   = 1'b0;
`endif

    // SCANIN is the pattern register's MSB flop; it drains to zero after the shift pass.
    assign bus.SCANIN = pat_q[N-1];
    wire unused_pat = ^pat_q;

    scan_shreg #(.N(N)) u_pat (
        .gclk(CLK), .grst_n(CLR), .clr(1'b0), .load(accept), .shift(pat_shift),
        .sin(1'b0), .d(bus.LOAD_DATA), .q(pat_q)
    );

    scan_shreg #(.N(N)) u_capt (
        .gclk(CLK), .grst_n(CLR), .clr(capt_clr), .load(1'b0), .shift(capt_shift),
        .sin(bus.SCANOUT), .d('0), .q(bus.CAPT_DATA)
    );

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bus.TEST <= 1'b0;
            bus.HOLD <= 1'b1;
            bus.BUSY <= 1'b0;
            bus.DONE <= 1'b0;
        end else begin
            bus.DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.START) begin
                        state    <= ST_SHIFT;
                        cnt      <= '0;
                        bus.TEST <= 1'b1;
                        bus.HOLD <= 1'b1;
                        bus.BUSY <= 1'b1;
                    end else begin
                        bus.HOLD <= ~bus.FUNC_EN;
                    end
                end
                ST_SHIFT: begin
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        cnt      <= '0;
                        bus.TEST <= 1'b0;
`ifdef SCAN_CAPTURE_EN
                        state    <= ST_CAPT;
                        bus.HOLD <= 1'b0;
`else
                        state    <= ST_FIN;
                        bus.DONE <= 1'b1;
`endif
                    end
                end
`ifdef SCAN_CAPTURE_EN
                ST_CAPT: begin
                    state    <= ST_UNLOAD;
                    cnt      <= '0;
                    bus.TEST <= 1'b1;
                    bus.HOLD <= 1'b1;
                end
                ST_UNLOAD: begin
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        cnt      <= '0;
                        state    <= ST_FIN;
                        bus.TEST <= 1'b0;
                        bus.DONE <= 1'b1;
                    end
                end
`endif
                ST_FIN: begin
                    state    <= ST_IDLE;
                    bus.BUSY <= 1'b0;
                    bus.HOLD <= ~bus.FUNC_EN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with a behavioural 8-bit scan chain and a
// scoreboard of expected SCANIN bits, CAPT_DATA and final chain contents.
module tb_scan_chain_ctrl;
    localparam int N = 8;
`ifdef SCAN_CAPTURE_EN
    localparam int LAT  = 2 * N + 2;
    localparam int TCNT = 2 * N;
`else
    localparam int LAT  = N + 1;
    localparam int TCNT = N;
`endif

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    scan_chain_ctrl_if #(.N(N)) bus();
    scan_chain_ctrl #(.N(N), .CW(4)) dut (.CLK(clk), .CLR(clr), .bus(bus));

    // behavioural chain: scan shift when TEST, functional load when HOLD low
    logic [N-1:0] chain = '0;
    logic [N-1:0] dval  = '0;
    logic         d_inv = 1'b0;
    logic [N-1:0] chain_d;
    assign chain_d     = d_inv ? ~chain : dval;
    assign bus.SCANOUT = chain[N-1];
    always @(posedge clk) begin
        if (bus.TEST)       chain <= {chain[N-2:0], bus.SCANIN};
        else if (!bus.HOLD) chain <= chain_d;
    end

    int n_chk = 0, n_fail = 0, done_cnt = 0, ops = 0;
    logic         sin_q[$];
    logic [N-1:0] capt_q[$];
    logic [N-1:0] chain_q[$];
    logic [N-1:0] model_chain;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_op(input logic [N-1:0] ld);
        for (int i = N - 1; i >= 0; i--) sin_q.push_back(ld[i]);
`ifdef SCAN_CAPTURE_EN
        for (int i = 0; i < N; i++) sin_q.push_back(1'b0);
        capt_q.push_back(d_inv ? ~ld : dval);
        chain_q.push_back('0);
        model_chain = '0;
`else
        capt_q.push_back(model_chain);
        chain_q.push_back(ld);
        model_chain = ld;
`endif
        ops++;
    endtask

    task automatic wait_ops();
        int n = 0;
        while ((done_cnt != ops || bus.BUSY) && n < 100) begin
            @(negedge clk); #1; n++;
        end
        chk("op_complete", done_cnt, ops);
    endtask

    // scoreboard consumer
    always @(negedge clk) begin
        if (clr) begin
            if (bus.TEST) begin
                if (sin_q.size() == 0) chk("scanin_unexpected", 1, 0);
                else chk("scanin", {31'd0, bus.SCANIN}, {31'd0, sin_q.pop_front()});
            end
            if (bus.DONE) begin
                if (capt_q.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    chk("capt_data", bus.CAPT_DATA, capt_q.pop_front());
                    chk("chain_after", chain, chain_q.pop_front());
                end
                done_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, tcnt, gap, n;
        logic [N-1:0] ld, frozen;
        bus.START = 1'b0; bus.LOAD_DATA = '0; bus.FUNC_EN = 1'b0;
        #2 clr = 1'b0;
        #1;
        chk("rst_test", bus.TEST, 0);
        chk("rst_hold", bus.HOLD, 1);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_done", bus.DONE, 0);
        chk("rst_capt", bus.CAPT_DATA, 0);
        chk("rst_scanin", bus.SCANIN, 0);
        repeat (2) @(negedge clk);
        clr = 1'b1;

        // functional mode: chain follows D, then holds
        bus.FUNC_EN = 1'b1; dval = 8'h3C;
        repeat (3) @(negedge clk);
        chk("func_hold_low", bus.HOLD, 0);
        chk("func_chain_load", chain, 8'h3C);
        bus.FUNC_EN = 1'b0;
        repeat (2) @(negedge clk);
        chk("func_hold_high", bus.HOLD, 1);
        dval = 8'h55;
        repeat (3) @(negedge clk);
        chk("func_chain_held", chain, 8'h3C);
        model_chain = 8'h3C;

        // basic load: latency and TEST width
        push_op(8'hA5);
        @(negedge clk); bus.START = 1'b1; bus.LOAD_DATA = 8'hA5;
        @(posedge clk); #1 bus.START = 1'b0; bus.LOAD_DATA = 8'h00;
        chk("accept_busy", bus.BUSY, 1);
        chk("accept_hold", bus.HOLD, 1);
        lat = 1; tcnt = bus.TEST ? 1 : 0;
        while (!bus.DONE && lat < 60) begin
            @(posedge clk); #1; lat++;
            if (bus.TEST) tcnt++;
        end
        chk("done_latency", lat, LAT);
        chk("test_cycles", tcnt, TCNT);
        @(posedge clk); #1;
        chk("done_pulse", bus.DONE, 0);
        wait_ops();

        // back-to-back with START held high
        push_op(8'hFF); push_op(8'h00);
        @(negedge clk); bus.START = 1'b1; bus.LOAD_DATA = 8'hFF;
        @(posedge clk); #1 bus.LOAD_DATA = 8'h00;
        n = 0;
        while (bus.BUSY && n < 60) begin @(posedge clk); #1; n++; end
        gap = 0;
        while (!bus.BUSY && gap < 10) begin @(posedge clk); #1; gap++; end
        chk("idle_gap", gap, 1);
        bus.START = 1'b0;
        wait_ops();

        // START during SHIFT is ignored
        push_op(8'h96);
        @(negedge clk); bus.START = 1'b1; bus.LOAD_DATA = 8'h96;
        @(posedge clk); #1 bus.START = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); bus.START = 1'b1; bus.LOAD_DATA = 8'h11;
        @(negedge clk); bus.START = 1'b0;
        wait_ops();
        repeat (3) @(negedge clk);
        chk("no_retrigger", bus.BUSY, 0);

        // asynchronous reset at shift count 3
        ld = 8'hC3;
        frozen = {model_chain[N-4:0], ld[N-1:N-3]};
        push_op(ld);
        @(negedge clk); bus.START = 1'b1; bus.LOAD_DATA = ld;
        @(posedge clk); #1 bus.START = 1'b0;
        repeat (3) @(posedge clk);
        #2 clr = 1'b0;
        #1;
        sin_q.delete(); capt_q.delete(); chain_q.delete(); ops--;
        chk("mid_rst_test", bus.TEST, 0);
        chk("mid_rst_hold", bus.HOLD, 1);
        chk("mid_rst_busy", bus.BUSY, 0);
        chk("mid_rst_done", bus.DONE, 0);
        chk("mid_rst_capt", bus.CAPT_DATA, 0);
        repeat (2) @(negedge clk);
        chk("mid_rst_frozen", chain, frozen);
        model_chain = frozen;
        clr = 1'b1;

        // random pattern after reset
        ld = N'($urandom);
        push_op(ld);
        @(negedge clk); bus.START = 1'b1; bus.LOAD_DATA = ld;
        @(posedge clk); #1 bus.START = 1'b0;
        wait_ops();
        chk("capt_stable", bus.CAPT_DATA, model_chain == ld ? frozen : '0);

`ifdef SCAN_CAPTURE_EN
        // capture pass with D = ~Q
        d_inv = 1'b1;
        push_op(8'h0F);
        @(negedge clk); bus.START = 1'b1; bus.LOAD_DATA = 8'h0F;
        @(posedge clk); #1 bus.START = 1'b0;
        lat = 1;
        while (!bus.DONE && lat < 60) begin @(posedge clk); #1; lat++; end
        chk("capt_latency", lat, LAT);
        chk("capt_response", bus.CAPT_DATA, 8'hF0);
        wait_ops();
        d_inv = 1'b0;
`endif

        chk("sb_empty", sin_q.size() + capt_q.size() + chain_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
